// File: rtl/seg_capture.sv
// seg_capture: watches a multiplexed 7-segment display bus and recovers,
// per digit position, the displayed hex nibble plus dot, blank and error
// flags. Strobe edges and ghosting are filtered by a stability counter.
module seg_capture #(
  parameter int DIGITS     = 4,
  parameter int STABLE     = 4,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            seg_in,
  input  logic [DIGITS-1:0]     dig_sel,
  output logic [4*DIGITS-1:0]   hex_out,
  output logic [DIGITS-1:0]     dot_out,
  output logic [DIGITS-1:0]     blank_out,
  output logic [DIGITS-1:0]     err_out,
  output logic                  upd,
  output logic [2:0]            upd_idx,
  output logic                  frame_done
);

  localparam int W = DIGITS + 8;
  localparam logic [7:0] CNT_MAX = 8'(STABLE - 1);
  // Inversion applied after the synchroniser; also the sample value seen
  // while s2 holds its cleared state, so prev starts equal to it and the
  // reset itself never looks like a bus change.
  localparam logic [W-1:0] INV_MASK = {W{ACTIVE_LOW}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  // Segment pattern (g..a) to {valid, nibble}; valid = 0 for anything else.
  function automatic logic [4:0] seg_decode(input logic [6:0] seg);
    logic [4:0] r;
    case (seg)
      7'h3F:   r = 5'h10;
      7'h06:   r = 5'h11;
      7'h5B:   r = 5'h12;
      7'h4F:   r = 5'h13;
      7'h66:   r = 5'h14;
      7'h6D:   r = 5'h15;
      7'h7D:   r = 5'h16;
      7'h07:   r = 5'h17;
      7'h7F:   r = 5'h18;
      7'h6F:   r = 5'h19;
      7'h77:   r = 5'h1A;
      7'h7C:   r = 5'h1B;
      7'h39:   r = 5'h1C;
      7'h5E:   r = 5'h1D;
      7'h79:   r = 5'h1E;
      7'h71:   r = 5'h1F;
      default: r = 5'h00;
    endcase
    return r;
  endfunction

  // True when exactly one strobe bit is set.
  function automatic logic dig_onehot(input logic [DIGITS-1:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      n = n + {3'd0, v[i]};
    end
    return (n == 4'd1);
  endfunction

  // Position of the set bit of a one-hot strobe vector.
  function automatic logic [2:0] dig_index(input logic [DIGITS-1:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < DIGITS; i++) begin
      r = r | (v[i] ? 3'(i) : 3'd0);
    end
    return r;
  endfunction

  logic [W-1:0]        s1_r, s2_r, prev_r, samp_s;
  logic [DIGITS-1:0]   sel_s, mask_r, mask_nxt_s;
  logic [7:0]          seg_s;
  logic [7:0]          cnt_r, cnt_nxt_s;
  logic                armed_r;
  state_t              state_r, state_nxt_s;
  logic                changed_s, onehot_s, capture_s;
  logic                blank_s, err_s;
  logic [4:0]          dec_s;
  logic [2:0]          idx_s;
  logic [4*DIGITS-1:0] hex_r;
  logic [DIGITS-1:0]   dot_r, blank_r, err_r;
  logic                upd_r, fd_r;
  logic [2:0]          upd_idx_r;

  assign samp_s = s2_r ^ INV_MASK;
  assign seg_s  = samp_s[W-1:DIGITS];
  assign sel_s  = samp_s[DIGITS-1:0];

  // Change detection, stability count and pattern decode of the current sample
  always_comb begin
    changed_s  = (samp_s != prev_r);
    onehot_s   = dig_onehot(sel_s);
    idx_s      = dig_index(sel_s);
    dec_s      = seg_decode(seg_s[6:0]);
    blank_s    = (seg_s[6:0] == 7'h00);
    err_s      = ~dec_s[4] & ~blank_s;
    mask_nxt_s = mask_r | sel_s;
    if (changed_s) begin
      cnt_nxt_s = 8'd0;
    end else if (cnt_r < CNT_MAX) begin
      cnt_nxt_s = cnt_r + 8'd1;
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Next-state logic; capture fires on the cycle the count reaches its limit
  always_comb begin
    state_nxt_s = state_r;
    capture_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (onehot_s) begin
          state_nxt_s = SETTLE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SETTLE: begin
        if (changed_s) begin
          state_nxt_s = onehot_s ? SETTLE : IDLE;
        end else if (armed_r && onehot_s && (cnt_nxt_s == CNT_MAX)) begin
          capture_s   = 1'b1;
          state_nxt_s = HOLD;
        end else begin
          state_nxt_s = SETTLE;
        end
      end
      HOLD: begin
        if (changed_s) begin
          state_nxt_s = onehot_s ? SETTLE : IDLE;
        end else begin
          state_nxt_s = HOLD;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Two-stage synchroniser and one-cycle-delayed copy of the sample
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_r   <= {W{1'b0}};
      s2_r   <= {W{1'b0}};
      prev_r <= INV_MASK;
    end else begin
      s1_r   <= {seg_in, dig_sel};
      s2_r   <= s1_r;
      prev_r <= samp_s;
    end
  end

  // Stability counter and arm flag (armed by a change, spent by a capture)
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r   <= 8'd0;
      armed_r <= 1'b0;
    end else begin
      cnt_r <= cnt_nxt_s;
      if (changed_s) begin
        armed_r <= 1'b1;
      end else if (capture_s) begin
        armed_r <= 1'b0;
      end else begin
        armed_r <= armed_r;
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Per-digit capture registers, update pulse and frame bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      hex_r     <= {(4*DIGITS){1'b0}};
      dot_r     <= {DIGITS{1'b0}};
      blank_r   <= {DIGITS{1'b1}};
      err_r     <= {DIGITS{1'b0}};
      upd_r     <= 1'b0;
      upd_idx_r <= 3'd0;
      fd_r      <= 1'b0;
      mask_r    <= {DIGITS{1'b0}};
    end else begin
      upd_r <= capture_s;
      fd_r  <= 1'b0;
      if (capture_s) begin
        upd_idx_r <= idx_s;
        for (int i = 0; i < DIGITS; i++) begin
          if (sel_s[i]) begin
            dot_r[i]   <= seg_s[7];
            blank_r[i] <= blank_s;
            err_r[i]   <= err_s;
            if (dec_s[4]) begin
              hex_r[4*i +: 4] <= dec_s[3:0];
            end
          end
        end
        if (&mask_nxt_s) begin
          fd_r   <= 1'b1;
          mask_r <= {DIGITS{1'b0}};
        end else begin
          mask_r <= mask_nxt_s;
        end
      end
    end
  end

  assign hex_out    = hex_r;
  assign dot_out    = dot_r;
  assign blank_out  = blank_r;
  assign err_out    = err_r;
  assign upd        = upd_r;
  assign upd_idx    = upd_idx_r;
  assign frame_done = fd_r;

endmodule

// File: doc/seg_capture.md
Name: seg_capture

Overview:
- Receive-side counterpart of the team's hex-to-7-segment decoder.
- Watches a multiplexed 7-segment display bus (segment lines plus one-hot digit strobes) and recovers a hex nibble, dot and blank/error flags for each digit position.
- Used for display loop-back self-test and for snooping legacy front panels into the mcs51 SFR space.
- Filters strobe transitions and ghosting with a stability counter. Emits a per-digit update pulse and a frame-complete pulse.

Parameters:
- DIGITS, 4: number of multiplexed digit positions (1..8).
- STABLE, 4: consecutive identical samples required before a capture (2..255).
- ACTIVE_LOW, 0: 1 = seg_in and dig_sel are active-low at the pins; both are inverted after synchronisation.

Ports:
- clk, input, 1: single clock, rising edge.
- rst, input, 1: synchronous, active-high reset.
- seg_in, input, 8: bit7 = dot, bits6:0 = segments g..a. Asynchronous to clk.
- dig_sel, input, DIGITS: digit strobes, one-hot when valid. Asynchronous to clk.
- hex_out, output, 4*DIGITS: recovered nibble; digit i occupies bits 4i+3:4i.
- dot_out, output, DIGITS: recovered dot per digit.
- blank_out, output, DIGITS: 1 = last capture had all 7 segments off.
- err_out, output, DIGITS: 1 = last capture was a non-hex, non-blank pattern.
- upd, output, 1: one-cycle pulse, some digit was just captured.
- upd_idx, output, 3: index of the digit captured. Valid only while upd = 1.
- frame_done, output, 1: one-cycle pulse, every digit has been captured since the previous pulse.

Behaviour:
- Reset (clk edge with rst = 1):
  - Clears sync registers, stability counter, armed flag and capture mask.
  - hex_out = 0, dot_out = 0, blank_out = all 1, err_out = 0, upd = 0, upd_idx = 0, frame_done = 0.
  - Reset mid-count discards any capture in progress.
- Synchroniser: {seg_in, dig_sel} pass through two flop stages (s1, s2), then the ACTIVE_LOW inversion. No logic between s1 and s2.
- Stability counter cnt (8 bits):
  - Every cycle, compare s2 against prev (s2 delayed one cycle).
  - If different: cnt = 0 and armed = 1.
  - If equal and cnt < STABLE-1: cnt increments.
  - cnt saturates at STABLE-1.
- State machine, states IDLE / SETTLE / HOLD:
  - IDLE: dig_sel is not exactly one-hot (zero or multiple bits). No capture. Goes to SETTLE when dig_sel becomes one-hot.
  - SETTLE: one-hot strobe, counting. When cnt == STABLE-1, s2 == prev and armed = 1, capture and go to HOLD.
  - HOLD: already captured; no further capture until s2 changes. A change goes to SETTLE, or to IDLE if the new dig_sel is not one-hot.
  - Exactly one capture per stable episode.
- Latency: if seg_in/dig_sel change at input cycle t and then stay constant, upd is high in cycle t+2+STABLE.
- Capture of digit i (i = index of the one-hot bit), all written on the same edge:
  - hex_out[i], dot_out[i], blank_out[i], err_out[i] are updated.
  - upd = 1 and upd_idx = i.
  - Mask bit i is set.
  - Other digits' outputs are unchanged.
- Decode table, segments g..a hex to nibble:
  - 3F=0, 06=1, 5B=2, 4F=3, 66=4, 6D=5, 7D=6, 07=7.
  - 7F=8, 6F=9, 77=A, 7C=B, 39=C, 5E=D, 79=E, 71=F.
  - 00: blank = 1, err = 0, nibble unchanged.
  - Any other pattern: err = 1, blank = 0, nibble unchanged.
  - On a valid hex pattern: blank = 0, err = 0.
  - The dot is always captured.
- frame_done:
  - When a capture sets the mask to all ones, frame_done pulses in the same cycle as upd, and the mask clears to 0 on that edge.
  - Re-capturing an already-set digit does not pulse frame_done.
- Simultaneous events:
  - A change on the same cycle as cnt reaching STABLE-1 aborts the capture (the change wins).
  - Strobe gaps with all-zero dig_sel are normal (IDLE) and do not clear the mask.

Test Plan:
- Reset, then idle inputs -> hex_out = 0, blank_out = 4'hF, err_out = 0, upd never asserts.
- Scan digits 0..3 with patterns 3F, 06, 5B, 4F (dot on digit 2), each held 10 cycles, STABLE = 4 -> hex_out = 16'h3210, dot_out = 4'b0100, four upd pulses with upd_idx 0..3, frame_done coincident with the 4th upd; each upd exactly 6 cycles after the input change.
- Hold digit 1 = 77 for only 3 cycles, then change -> no upd; hex_out[1] keeps its old value.
- dig_sel = 4'b0011 with seg 7F held 20 cycles -> no capture. Then dig_sel = 4'b0010 -> one upd, hex_out[7:4] = 8.
- Digit 3 pattern 12 -> err_out[3] = 1, hex_out[15:12] unchanged. Then 00 -> blank_out[3] = 1, err_out[3] = 0.
- ACTIVE_LOW = 1, inverted pins for 71 on digit 0 -> hex_out[3:0] = F. Assert rst while cnt = 2 -> no upd; mask and outputs at their reset values.
